// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32 integer pipeline.
// Operation codes, opcode fields and the ID->EX ALU payload.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SLL  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SRL  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_AND  = 5'd7;
  localparam logic [4:0] ALU_SUB  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_FWD  = 5'd16;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } alu_req_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-class decode into an ALU payload.
// Non-ALU encodings yield an illegal, non-writing ADD payload.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_req_t    req
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        ok;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    ok = 1'b0;
    op = ALU_ADD;
    a  = '0;
    b  = '0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        a = rs1_data;
        b = rs2_data;
        if (f7 == F7_BASE) begin
          ok = 1'b1;
          op = {2'b00, f3};
        end else if (f7 == F7_ALT &&
                     (f3 == F3_ADD || f3 == F3_SR)) begin
          ok = 1'b1;
          op = {2'b01, f3};
        end
      end
      (opc == OPC_IMM): begin
        a = rs1_data;
        if (f3 == F3_SLL) begin
          ok = (f7 == F7_BASE);
          op = ALU_SLL;
          b  = shamt;
        end else if (f3 == F3_SR) begin
          // instr[30] picks arithmetic vs logical
          ok = ~instr[31] & (instr[29:25] == 5'b0);
          op = {1'b0, instr[30], f3};
          b  = shamt;
        end else begin
          ok = 1'b1;
          op = {2'b00, f3};
          b  = imm_i;
        end
      end
      (opc == OPC_LUI): begin
        ok = 1'b1;
        op = ALU_FWD;
        b  = imm_u;
      end
      (opc == OPC_AUIPC): begin
        ok = 1'b1;
        op = ALU_ADD;
        a  = pc;
        b  = imm_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    req         = '0;
    req.rd      = instr[11:7];
    req.illegal = ~ok;
    if (ok) begin
      req.alu_op = op;
      req.op1    = a;
      req.op2    = b;
      req.we     = |instr[11:7];
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX ALU issue: decode plus a 2-entry skid buffer.
// Main entry drives EX; skid absorbs one payload under stall.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [31:0]         INSTR,
  input  logic [XLEN-1:0]     PC,
  input  logic [XLEN-1:0]     RS1_DATA,
  input  logic [XLEN-1:0]     RS2_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic [XLEN-1:0]     OP1,
  output logic [XLEN-1:0]     OP2,
  output logic [4:0]          RD_ADDR,
  output logic                REG_WRITE_EN,
  output logic                ILLEGAL
);

  alu_req_t dec;
  alu_req_t main_q, main_n;
  alu_req_t skid_q, skid_n;
  logic     main_v, main_vn;
  logic     skid_v, skid_vn;
  logic     rdy_q;
  logic     accept;
  logic     drain;
  logic     adv;

  alu_op_decode u_dec (
    .instr    (INSTR),
    .pc       (PC),
    .rs1_data (RS1_DATA),
    .rs2_data (RS2_DATA),
    .req      (dec)
  );

  assign accept = IN_VALID & rdy_q;
  assign drain  = main_v & OUT_READY;
  assign adv    = drain | ~main_v;

  // accept implies skid empty, so skid refill and capture never collide
  always_comb begin
    main_n  = main_q;
    skid_n  = skid_q;
    main_vn = main_v;
    skid_vn = skid_v;
    if (adv) begin
      if (skid_v) begin
        main_n  = skid_q;
        main_vn = 1'b1;
        skid_vn = 1'b0;
      end else begin
        main_vn = accept;
        if (accept) main_n = dec;
      end
    end else if (accept) begin
      skid_n  = dec;
      skid_vn = 1'b1;
    end
    if (FLUSH) begin
      main_vn = 1'b0;
      skid_vn = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_n;
      skid_q <= skid_n;
      main_v <= main_vn;
      skid_v <= skid_vn;
      rdy_q  <= ~skid_vn;
    end
  end

  assign IN_READY     = rdy_q;
  assign OUT_VALID    = main_v;
  assign ALU_OP       = main_q.alu_op;
  assign OP1          = main_q.op1;
  assign OP2          = main_q.op2;
  assign RD_ADDR      = main_q.rd;
  assign REG_WRITE_EN = main_q.we;
  assign ILLEGAL      = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd;
  logic        we;
  logic        ill;

  int n_vec;
  int n_err;
  int seen;

  alu_issue_stage dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .FLUSH        (flush),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .INSTR        (instr),
    .PC           (pc),
    .RS1_DATA     (rs1),
    .RS2_DATA     (rs2),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .ALU_OP       (alu_op),
    .OP1          (op1),
    .OP2          (op2),
    .RD_ADDR      (rd),
    .REG_WRITE_EN (we),
    .ILLEGAL      (ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_pay(input string tag,
                         input logic [4:0] e_op,
                         input logic [31:0] e_o1,
                         input logic [31:0] e_o2,
                         input logic [4:0] e_rd,
                         input logic e_we,
                         input logic e_il);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".op"}, {27'b0, alu_op}, {27'b0, e_op});
    chk({tag, ".op1"}, op1, e_o1);
    chk({tag, ".op2"}, op2, e_o2);
    chk({tag, ".rd"}, {27'b0, rd}, {27'b0, e_rd});
    chk({tag, ".we"}, {31'b0, we}, {31'b0, e_we});
    chk({tag, ".ill"}, {31'b0, ill}, {31'b0, e_il});
  endtask

  task automatic send(input logic [31:0] i,
                      input logic [31:0] p,
                      input logic [31:0] a,
                      input logic [31:0] b);
    instr    = i;
    pc       = p;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = $urandom;
    pc        = $urandom;
    rs1       = $urandom;
    rs2       = $urandom;

    // reset with random inputs
    repeat (3) @(negedge clk);
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.op", {27'b0, alu_op}, 32'd0);
    chk("rst.op1", op1, 32'd0);
    chk("rst.op2", op2, 32'd0);
    chk("rst.rd", {27'b0, rd}, 32'd0);
    chk("rst.we", {31'b0, we}, 32'd0);
    chk("rst.ill", {31'b0, ill}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rst.ready", {31'b0, in_ready}, 32'd1);

    // streaming decode, one per cycle
    send(32'hFFD08293, 32'h100, 32'h10, 32'h0);
    chk_pay("addi", 5'd0, 32'h10, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0);
    send(32'h40415193, 32'h104, 32'h80000000, 32'h0);
    chk_pay("srai", 5'd13, 32'h80000000, 32'h4, 5'd3, 1'b1, 1'b0);
    send(32'h123453B7, 32'h108, 32'h55, 32'h66);
    chk_pay("lui", 5'd16, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0);
    send(32'h00001097, 32'h2000, 32'h55, 32'h66);
    chk_pay("auipc", 5'd0, 32'h2000, 32'h1000, 5'd1, 1'b1, 1'b0);
    send(32'h02208033, 32'h110, 32'h7, 32'h9);
    chk_pay("mul", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    send(32'h00208033, 32'h114, 32'h7, 32'h9);
    chk_pay("add_x0", 5'd0, 32'h7, 32'h9, 5'd0, 1'b0, 1'b0);
    send(32'h40208233, 32'h118, 32'h20, 32'h3);
    chk_pay("sub", 5'd8, 32'h20, 32'h3, 5'd4, 1'b1, 1'b0);
    send(32'h40109093, 32'h11C, 32'h1, 32'h2);
    chk_pay("slli_bad", 5'd0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("drained", {31'b0, out_valid}, 32'd0);

    // backpressure fills both entries
    out_ready = 1'b0;
    send(32'hFFD08293, 32'h200, 32'h10, 32'h0);
    chk("bp.ready1", {31'b0, in_ready}, 32'd1);
    send(32'h123453B7, 32'h204, 32'h0, 32'h0);
    chk("bp.ready2", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk_pay("bp.hold", 5'd0, 32'h10, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_pay("bp.first", 5'd0, 32'h10, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk_pay("bp.second", 5'd16, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0);
    chk("bp.ready3", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp.empty", {31'b0, out_valid}, 32'd0);

    // flush with both entries full and a third offered
    out_ready = 1'b0;
    send(32'h00208033, 32'h300, 32'h1, 32'h2);
    send(32'h40208233, 32'h304, 32'h3, 32'h4);
    flush = 1'b1;
    send(32'hFFD08293, 32'h308, 32'h5, 32'h0);
    flush = 1'b0;
    chk("fl.valid", {31'b0, out_valid}, 32'd0);
    chk("fl.ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("fl.none", seen, 32'd0);

    // asynchronous reset mid-operation
    send(32'h123453B7, 32'h400, 32'h0, 32'h0);
    out_ready = 1'b0;
    chk("ar.before", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", {31'b0, out_valid}, 32'd0);
    chk("ar.op", {27'b0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar.ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the integer ALU interface (ID→EX boundary of the RV32IM pipeline).
- Decodes one RV32I ALU-class instruction per transfer into ALU_OP, OP1 and OP2, plus writeback control.
- Registers the decoded payload behind a 2-entry skid buffer with valid/ready handshakes, so the EX stage sees registered operands and upstream sees a registered ready.

Parameters:
- XLEN, 32, data width of operands, PC and register data.
- ALU_OP_W, 5, width of the ALU operation code.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- FLUSH  input  1  synchronous pipeline flush (branch mispredict/trap)
- IN_VALID  input  1  decode stage presents an instruction
- IN_READY  output  1  block can accept; registered
- INSTR  input  32  instruction word
- PC  input  XLEN  instruction address
- RS1_DATA  input  XLEN  register-file read port 1
- RS2_DATA  input  XLEN  register-file read port 2
- OUT_VALID  output  1  decoded payload valid toward EX
- OUT_READY  input  1  EX stage accepts payload
- ALU_OP  output  ALU_OP_W  operation code to ALU
- OP1  output  XLEN  ALU operand 1
- OP2  output  XLEN  ALU operand 2
- RD_ADDR  output  5  destination register
- REG_WRITE_EN  output  1  writeback enable
- ILLEGAL  output  1  instruction not an ALU-class op

Behaviour:
- Reset (RESET=0, asynchronous): both entries invalid. OUT_VALID=0, ALU_OP=0, OP1=OP2=0, RD_ADDR=0, REG_WRITE_EN=0, ILLEGAL=0. IN_READY=1 from the first edge after release.
- ALU_OP codes:
  - ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13, FORWARD=16.
  - For OP and shift-immediate instructions, code = {0, funct7[5], funct3}.
  - SUB=8 is reserved for the pending ALU update and is emitted now.
- Decode (combinational, captured on acceptance):
  - OP (0110011):
    - funct7=0000000 → {0,funct3}.
    - funct7=0100000 with funct3 000 or 101 → SUB or SRA.
    - OP1=RS1_DATA, OP2=RS2_DATA.
  - OP-IMM (0010011):
    - OP2 = sign-extended INSTR[31:20].
    - SLLI requires INSTR[31:25]=0. SRLI/SRAI select on INSTR[30] with INSTR[31,29:25]=0.
    - For shifts, OP2 = zero-extended INSTR[24:20].
  - LUI: ALU_OP=FORWARD, OP2={INSTR[31:12],12'b0}, OP1=0.
  - AUIPC: ALU_OP=ADD, OP1=PC, OP2={INSTR[31:12],12'b0}.
  - All other encodings, including M-extension funct7=0000001: ILLEGAL=1, ALU_OP=ADD, REG_WRITE_EN=0, OP1=OP2=0, payload still delivered.
  - REG_WRITE_EN=1 for legal instructions with rd≠0. RD_ADDR=INSTR[11:7].
- Handshake:
  - Accept when IN_VALID&IN_READY. Transfer out when OUT_VALID&OUT_READY.
  - Latency: payload accepted in cycle N appears with OUT_VALID=1 in cycle N+1 when the main entry is empty or draining.
  - Main entry drives outputs. The skid entry captures an accepted payload when main is full and not draining.
  - IN_READY = ~skid_valid (registered).
  - Skid refills main when main drains. Strict FIFO order, no loss or duplication.
  - Outputs are held stable while OUT_VALID=1 and OUT_READY=0.
- Simultaneous accept and drain with main full and skid empty: the new payload moves into main, the old one leaves. Throughput is 1/cycle.
- FLUSH:
  - Next cycle both entries are invalid, OUT_VALID=0, IN_READY=1.
  - An input presented in the FLUSH cycle is dropped.
  - FLUSH has priority over accept and drain. An output transfer in the same cycle still counts as completed at EX.
- Reset mid-operation discards all entries immediately (asynchronous).

Decomposition:
- Shared package alu_pkg:
  - ALU_OP code constants (shared with the ALU).
  - RV32 opcode and funct constants.
  - Payload struct {alu_op, op1, op2, rd, we, illegal}.
- Sub-module alu_op_decode: purely combinational INSTR/PC/RS data → payload.
- The top holds the skid-buffer control and registers.

Test Plan:
- Reset: hold RESET=0 with random inputs → OUT_VALID=0, ALU_OP=0, OP1=OP2=0, REG_WRITE_EN=0; IN_READY=1 after release.
- ADDI x5,x1,-3: INSTR=0xFFD08293, RS1_DATA=0x10, OUT_READY=1 → next cycle OUT_VALID=1, ALU_OP=0, OP1=0x10, OP2=0xFFFFFFFD, RD_ADDR=5, REG_WRITE_EN=1.
- SRAI x3,x2,4: INSTR=0x40415193, RS1_DATA=0x80000000 → ALU_OP=13, OP2=4. LUI x7,0x12345: INSTR=0x123453B7 → ALU_OP=16, OP1=0, OP2=0x12345000.
- Illegal/M-ext: MUL INSTR=0x02208033 → ILLEGAL=1, REG_WRITE_EN=0, ALU_OP=0. ADD with rd=x0 → REG_WRITE_EN=0.
- Backpressure: OUT_READY=0, issue two instructions back-to-back → IN_READY=0 after the second is accepted, outputs stable for 3 cycles. Raise OUT_READY → both delivered in order on consecutive cycles, IN_READY returns to 1.
- Flush: both entries full, IN_VALID=1 with a third instruction, FLUSH=1 → next cycle OUT_VALID=0, IN_READY=1, none of the three ever delivered.
